// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared ALU types and constants.
//   word_t       : 64-bit datapath word
//   logic_op_t   : opcode of the bitwise logic stage (AND / OR / XOR / pass-B)
//   GATE_DELAY   : nominal per-gate delay in ps, for timing annotation only
//   zero_levels  : number of 4-input OR levels needed to reduce a word
//   level_offset : start index of a reduction level in a flattened node vector
// ----------------------------------------------------------------------------
`timescale 1ps/1fs
package alu_pkg;

   typedef logic [63:0] word_t;

   typedef enum logic [1:0] {
      LOG_AND   = 2'b00,
      LOG_OR    = 2'b01,
      LOG_XOR   = 2'b10,
      LOG_PASSB = 2'b11
   } logic_op_t;

   localparam int GATE_DELAY = 50;

   // Smallest L such that 4**L >= w.
   function automatic int zero_levels(input int w);
      int l;
      int cap;
      l   = 0;
      cap = 1;
      while (cap < w) begin
         cap = cap * 4;
         l   = l + 1;
      end
      return l;
   endfunction

   // Nodes of level 0 occupy [0, pad), level 1 follows with pad/4 nodes, etc.
   function automatic int level_offset(input int pad, input int l);
      int off;
      int n;
      off = 0;
      n   = pad;
      for (int k = 0; k < l; k++) begin
         off = off + n;
         n   = n / 4;
      end
      return off;
   endfunction

endpackage

// File: rtl/logic_bit_slice.sv
// ----------------------------------------------------------------------------
// logic_bit_slice
// One bit of the logic stage: AND/OR/XOR gates plus a gate-level 4:1 mux
// selecting the result by opcode (00 AND, 01 OR, 10 XOR, 11 pass B).
// Ports:
//   i_a, i_b  : operand bits
//   i_op      : 2-bit opcode
//   o_and     : i_a & i_b
//   o_or      : i_a | i_b
//   o_xor     : i_a ^ i_b
//   o_sel     : opcode-selected bit
// ----------------------------------------------------------------------------
`timescale 1ps/1fs
module logic_bit_slice (
   input  logic       i_a,
   input  logic       i_b,
   input  logic [1:0] i_op,
   output logic       o_and,
   output logic       o_or,
   output logic       o_xor,
   output logic       o_sel
);

   logic w_ns0;
   logic w_ns1;
   logic w_t0;
   logic w_t1;
   logic w_t2;
   logic w_t3;

   and g_and (o_and, i_a, i_b);
   or  g_or  (o_or,  i_a, i_b);
   xor g_xor (o_xor, i_a, i_b);

   // Sum-of-products mux: exactly one decode term is active per opcode.
   not g_ns0 (w_ns0, i_op[0]);
   not g_ns1 (w_ns1, i_op[1]);

   and g_t0 (w_t0, w_ns1,   w_ns0,   o_and);
   and g_t1 (w_t1, w_ns1,   i_op[0], o_or);
   and g_t2 (w_t2, i_op[1], w_ns0,   o_xor);
   and g_t3 (w_t3, i_op[1], i_op[0], i_b);

   or  g_sel (o_sel, w_t0, w_t1, w_t2, w_t3);

endmodule

// File: rtl/bitwise_logic_unit.sv
// ----------------------------------------------------------------------------
// bitwise_logic_unit
// Bitwise logic stage of the ALU. Computes A&B, A|B, A^B per bit, selects one
// by opcode and registers it together with zero/negative flags (1-cycle
// latency). Asynchronous active-low reset clears the register bank.
// Ports:
//   clk       : clock, rising edge
//   reset     : async active-low reset
//   A, B      : operands (WIDTH)
//   op        : 00 AND, 01 OR, 10 XOR, 11 pass B
//   valid_in  : operands/op valid this cycle
//   and_out   : combinational A & B
//   or_out    : combinational A | B
//   xor_out   : combinational A ^ B
//   result    : registered selected value
//   zero      : registered (selected value == 0)
//   negative  : registered MSB of selected value
//   valid_out : registered valid_in
// ----------------------------------------------------------------------------
`timescale 1ps/1fs
module bitwise_logic_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op,
   input  logic             valid_in,
   output logic [WIDTH-1:0] and_out,
   output logic [WIDTH-1:0] or_out,
   output logic [WIDTH-1:0] xor_out,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             valid_out
);

   localparam int ZLEVELS = zero_levels(WIDTH);
   localparam int PAD     = 4 ** ZLEVELS;
   localparam int NODES   = level_offset(PAD, ZLEVELS) + 1;

   logic [WIDTH-1:0] w_sel;
   logic [NODES-1:0] w_ztree;
   logic             w_zero_next;

   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_negative;
   logic             r_valid_out;

   // Per-bit datapath: no cross-bit signals anywhere in the slices.
   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      logic_bit_slice u_slice (
         .i_a   (A[i]),
         .i_b   (B[i]),
         .i_op  (op),
         .o_and (and_out[i]),
         .o_or  (or_out[i]),
         .o_xor (xor_out[i]),
         .o_sel (w_sel[i])
      );
   end

   // Zero detect on the selected value (not on the stored result), as a tree
   // of 4-input ORs. Leaves beyond WIDTH are tied low by the zero-extension.
   assign w_ztree[PAD-1:0] = PAD'(w_sel);

   for (genvar l = 0; l < ZLEVELS; l++) begin : g_zlevel
      localparam int SRC = level_offset(PAD, l);
      localparam int DST = level_offset(PAD, l + 1);
      localparam int CNT = PAD / (4 ** (l + 1));
      for (genvar n = 0; n < CNT; n++) begin : g_znode
         or g_or4 (w_ztree[DST+n],
                   w_ztree[SRC+4*n],   w_ztree[SRC+4*n+1],
                   w_ztree[SRC+4*n+2], w_ztree[SRC+4*n+3]);
      end
   end

   not g_zinv (w_zero_next, w_ztree[NODES-1]);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_result    <= '0;
         r_zero      <= 1'b1;
         r_negative  <= 1'b0;
         r_valid_out <= 1'b0;
      end else begin
         r_valid_out <= valid_in;
         if (valid_in) begin
            r_result   <= w_sel;
            r_zero     <= w_zero_next;
            r_negative <= w_sel[WIDTH-1];
         end
      end
   end

   assign result    = r_result;
   assign zero      = r_zero;
   assign negative  = r_negative;
   assign valid_out = r_valid_out;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// ----------------------------------------------------------------------------
// tb_bitwise_logic_unit
// Directed and randomized checks of bitwise_logic_unit against a behavioural
// model (plain operators on whole words, held in a few expected-value vars).
// ----------------------------------------------------------------------------
`timescale 1ps/1fs
module tb_bitwise_logic_unit;
   import alu_pkg::*;

   logic        clk;
   logic        reset;
   word_t       A;
   word_t       B;
   logic [1:0]  op;
   logic        valid_in;
   word_t       and_out;
   word_t       or_out;
   word_t       xor_out;
   word_t       result;
   logic        zero;
   logic        negative;
   logic        valid_out;

   int checks = 0;
   int errors = 0;

   word_t exp_result;
   logic  exp_zero;
   logic  exp_neg;
   logic  exp_valid;

   bitwise_logic_unit #(.WIDTH(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .A         (A),
      .B         (B),
      .op        (op),
      .valid_in  (valid_in),
      .and_out   (and_out),
      .or_out    (or_out),
      .xor_out   (xor_out),
      .result    (result),
      .zero      (zero),
      .negative  (negative),
      .valid_out (valid_out)
   );

   initial clk = 1'b0;
   always #500 clk = ~clk;

   task automatic check(input string tag, input word_t observed, input word_t expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic word_t model_sel(input logic_op_t o, input word_t a, input word_t b);
      case (o)
         LOG_AND: return a & b;
         LOG_OR:  return a | b;
         LOG_XOR: return a ^ b;
         default: return b;
      endcase
   endfunction

   task automatic model_reset();
      exp_result = '0;
      exp_zero   = 1'b1;
      exp_neg    = 1'b0;
      exp_valid  = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".result"},    result,           exp_result);
      check({tag, ".zero"},      word_t'(zero),      word_t'(exp_zero));
      check({tag, ".negative"},  word_t'(negative),  word_t'(exp_neg));
      check({tag, ".valid_out"}, word_t'(valid_out), word_t'(exp_valid));
   endtask

   // One cycle: drive on the falling edge, check combinational outputs after
   // more than a gate delay, optionally pulse reset before the rising edge,
   // then check the registered outputs shortly after the rising edge.
   task automatic step(input string tag, input word_t a, input word_t b,
                       input logic [1:0] o, input logic v, input bit rst_mid);
      word_t sel;
      @(negedge clk);
      A        = a;
      B        = b;
      op       = o;
      valid_in = v;
      #(2 * GATE_DELAY);
      check({tag, ".and"}, and_out, a & b);
      check({tag, ".or"},  or_out,  a | b);
      check({tag, ".xor"}, xor_out, a ^ b);
      if (rst_mid) begin
         reset = 1'b0;
         #20;
         model_reset();
         check_regs({tag, ".async_rst"});
         #50;
         reset = 1'b1;
      end
      @(posedge clk);
      #100;
      sel = model_sel(logic_op_t'(o), a, b);
      if (v) begin
         exp_result = sel;
         exp_zero   = (sel == 64'd0);
         exp_neg    = sel[63];
         exp_valid  = 1'b1;
      end else begin
         exp_valid  = 1'b0;
      end
      check_regs(tag);
   endtask

   initial begin
      reset    = 1'b0;
      A        = '0;
      B        = '0;
      op       = 2'b00;
      valid_in = 1'b1;
      model_reset();

      // Reset held across edges with valid_in high: nothing captured.
      repeat (2) @(posedge clk);
      #100;
      check_regs("reset_hold");
      @(negedge clk);
      reset = 1'b1;

      step("vec_mask",  64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00, 2'b00, 1'b0, 1'b0);
      check("vec_mask.and_const", and_out, 64'hFF00_0000_FF00_0000);
      check("vec_mask.or_const",  or_out,  64'hFFFF_FF00_FFFF_FF00);
      check("vec_mask.xor_const", xor_out, 64'h00FF_FF00_00FF_FF00);

      step("and_alt",   {16{4'hA}}, {16{4'h5}}, 2'b00, 1'b1, 1'b0);
      check("and_alt.result_const", result, 64'd0);
      check("and_alt.zero_const",   word_t'(zero), 64'd1);

      step("or_msb",    64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b1, 1'b0);
      check("or_msb.result_const", result, 64'h8000_0000_0000_0001);
      check("or_msb.neg_const",    word_t'(negative), 64'd1);

      step("xor_same",  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 2'b10, 1'b1, 1'b0);
      step("passb",     64'hDEAD_BEEF_0000_0000, 64'd7, 2'b11, 1'b1, 1'b0);
      check("passb.result_const", result, 64'd7);

      // Load all ones, then idle three cycles with changing operands.
      step("load_ones", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         step("idle_hold", $urandom(), 64'd0, 2'b00, 1'b0, 1'b0);
      check("idle_hold.result_const", result, 64'hFFFF_FFFF_FFFF_FFFF);

      // Async reset between edges with a nonzero result, then normal capture.
      step("rst_mid",   64'h0F0F, 64'hF0F0, 2'b01, 1'b1, 1'b1);
      check("rst_mid.result_const", result, 64'hFFFF);

      // Randomized sweep with occasional mid-cycle resets.
      for (int i = 0; i < 300; i++) begin
         word_t      ra;
         word_t      rb;
         logic [1:0] ro;
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         ro = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) rb = ra;           // exercise zero via XOR
         if ($urandom_range(0, 7) == 0) ra = ~rb;          // exercise zero via AND
         step("rand", ra, rb, ro, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 19) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
